// File: rtl/output_pkg.sv
// Shared types and constants for the output frame ping-pong scheduler.
package output_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_e;

  localparam int FRAME_WORDS     = 19200;
  localparam int SHORTS_PER_WORD = 16;
  localparam int DONE_PIPE_DEPTH = 12;

  // Shortest legal watchdog: one full fetch plus the done pipeline.
  localparam int MIN_TIMEOUT     = FRAME_WORDS * SHORTS_PER_WORD + DONE_PIPE_DEPTH;
  localparam int TIMEOUT_DEFAULT = 400000;

endpackage

// File: rtl/frame_watchdog.sv
// Loadable up-counter with clear and enable; expired flags count == LIMIT-1.
module frame_watchdog #(
  parameter int CNT_W = 20,
  parameter int LIMIT = 400000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/output_frame_scheduler.sv
// Ping-pong controller for the output frame memory: bank full flags,
// write grant to compute, and the start/done handshake with the fetch stage.
module output_frame_scheduler
  import output_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_frame_done,
  input  logic        sink_ready,
  input  logic        fetch_done,
  output logic        fetch_start,
  output logic        output_base_offset,
  output logic        wr_bank,
  output logic        wr_grant,
  output logic [15:0] frame_count,
  output logic        overrun_err,
  output logic        timeout_err
);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic [1:0]  r_full;
  logic [1:0]  w_full_next;
  logic        r_wr_bank;
  logic        r_rd_bank;
  logic        r_wr_grant;
  logic        r_fetch_start;
  logic [15:0] r_frame_count;
  logic        r_overrun_err;
  logic        r_timeout_err;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;
  logic w_frame_ok;
  logic w_frame_timeout;
  logic w_wr_accept;

  frame_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_clear    (w_wd_clear),
    .i_enable   (w_wd_enable),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .o_expired  (w_wd_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_wd_clear      = 1'b0;
    w_wd_enable     = 1'b0;
    w_frame_ok      = 1'b0;
    w_frame_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank] && sink_ready && !fetch_done) begin
          w_state_next = ST_RUN;
          w_wd_clear   = 1'b1;
        end
      end
      ST_RUN: begin
        w_wd_enable = 1'b1;
        if (fetch_done) begin
          w_frame_ok   = 1'b1;
          w_state_next = ST_RELEASE;
        end else if (w_wd_expired) begin
          w_frame_timeout = 1'b1;
          w_state_next    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Drain the stale done level of the finished frame before re-arming.
        if (!fetch_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_wr_accept = wr_frame_done && r_wr_grant;

  // Read-side clear is applied before the write-side set of the same cycle.
  always_comb begin
    w_full_next = r_full;
    if (w_frame_ok || w_frame_timeout) begin
      w_full_next[r_rd_bank] = 1'b0;
    end
    if (w_wr_accept) begin
      w_full_next[r_wr_bank] = 1'b1;
    end
  end

  // NOTE: only control state is reset here; there is no storage array in this block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_grant    <= 1'b1;
      r_fetch_start <= 1'b0;
      r_frame_count <= 16'd0;
      r_overrun_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_full        <= w_full_next;
      r_wr_grant    <= !r_full[r_wr_bank];
      r_fetch_start <= (w_state_next == ST_RUN);
      if (w_wr_accept) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (wr_frame_done && !r_wr_grant) begin
        r_overrun_err <= 1'b1;
      end
      if (w_frame_ok || w_frame_timeout) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_frame_ok) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_frame_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign fetch_start        = r_fetch_start;
  assign output_base_offset = r_rd_bank;
  assign wr_bank            = r_wr_bank;
  assign wr_grant           = r_wr_grant;
  assign frame_count        = r_frame_count;
  assign overrun_err        = r_overrun_err;
  assign timeout_err        = r_timeout_err;

endmodule
